// File: rtl/ir_sense_seq.sv
// ir_sense_seq: pulses the IR emitters, sequences left/right A2D conversions and publishes
// readings, wall-open flags and the derivative term. Build macro IR_HYST_EN adds open-flag hysteresis.
module ir_sense_seq #(
  parameter logic [19:0] PERIOD    = 20'd1000000,
  parameter logic [15:0] SETTLE    = 16'd4096,
  parameter logic [2:0]  LFT_CHNL  = 3'd3,
  parameter logic [2:0]  RGHT_CHNL = 3'd0,
  parameter logic [11:0] OPN_THRES = 12'h400,
`ifdef IR_HYST_EN
  parameter logic [11:0] HYST      = 12'h080,
`endif
  parameter int          D_SHIFT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        a2d_cnv_cmplt,
  input  logic [11:0] a2d_res,
  output logic        a2d_strt,
  output logic [2:0]  a2d_chnl,
  output logic        IR_en,
  output logic [11:0] lft_IR,
  output logic [11:0] rght_IR,
  output logic        lft_opn,
  output logic        rght_opn,
  output logic [8:0]  IR_Dtrm,
  output logic        IR_vld
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CNV_L  = 3'd2,
    ST_WAIT_L = 3'd3,
    ST_CNV_R  = 3'd4,
    ST_WAIT_R = 3'd5,
    ST_UPDATE = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [19:0]        per_cnt_q, per_cnt_d;
  logic [15:0]        settle_cnt_q, settle_cnt_d;
  logic               tick_s, settle_done_s, upd_s;
  logic [11:0]        lft_rd_q, lft_rd_d;
  logic signed [12:0] diff_prev_q, diff_prev_d;
  logic               first_q, first_d;

  logic               a2d_strt_q, a2d_strt_d;
  logic [2:0]         a2d_chnl_q, a2d_chnl_d;
  logic               ir_en_q, ir_en_d;
  logic [11:0]        lft_ir_q, lft_ir_d;
  logic [11:0]        rght_ir_q, rght_ir_d;
  logic               lft_opn_q, lft_opn_d;
  logic               rght_opn_q, rght_opn_d;
  logic [8:0]         ir_dtrm_q, ir_dtrm_d;
  logic               ir_vld_q, ir_vld_d;

  logic               lft_opn_new_s, rght_opn_new_s;
  logic signed [12:0] diff_s;
  logic signed [13:0] delta_s, shift_s;
  logic [8:0]         dtrm_sat_s;

`ifdef IR_HYST_EN
  // Set below threshold, clear above threshold+band, hold inside the band.
  function automatic logic opn_next(input logic [11:0] rd, input logic prev);
    logic [12:0] clr_lvl;
    clr_lvl = {1'b0, OPN_THRES} + {1'b0, HYST};
    if ({1'b0, rd} < {1'b0, OPN_THRES}) begin
      return 1'b1;
    end else if ({1'b0, rd} > clr_lvl) begin
      return 1'b0;
    end else begin
      return prev;
    end
  endfunction
`else
  function automatic logic opn_next(input logic [11:0] rd);
    return (rd < OPN_THRES);
  endfunction
`endif

  // Free-running sample-period counter and settle counter.
  always_comb begin
    tick_s        = (per_cnt_q == (PERIOD - 20'd1));
    settle_done_s = (settle_cnt_q == (SETTLE - 16'd1));
    if (tick_s) begin
      per_cnt_d = 20'd0;
    end else begin
      per_cnt_d = per_cnt_q + 20'd1;
    end
    if (state_q == ST_SETTLE) begin
      settle_cnt_d = settle_cnt_q + 16'd1;
    end else begin
      settle_cnt_d = 16'd0;
    end
  end

  // Sequencer next-state logic; a busy tick is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_s && en) state_d = ST_SETTLE;
        else              state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (settle_done_s) state_d = ST_CNV_L;
        else               state_d = ST_SETTLE;
      end
      ST_CNV_L:  state_d = ST_WAIT_L;
      ST_WAIT_L: begin
        if (a2d_cnv_cmplt) state_d = ST_CNV_R;
        else               state_d = ST_WAIT_L;
      end
      ST_CNV_R:  state_d = ST_WAIT_R;
      ST_WAIT_R: begin
        if (a2d_cnv_cmplt) state_d = ST_UPDATE;
        else               state_d = ST_WAIT_R;
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Flags, derivative and registered-output next values; outputs load as UPDATE is entered.
  always_comb begin
    upd_s = (state_q == ST_WAIT_R) && a2d_cnv_cmplt;

    if ((state_q == ST_WAIT_L) && a2d_cnv_cmplt) begin
      lft_rd_d = a2d_res;
    end else begin
      lft_rd_d = lft_rd_q;
    end

`ifdef IR_HYST_EN
    lft_opn_new_s  = opn_next(lft_rd_q, lft_opn_q);
    rght_opn_new_s = opn_next(a2d_res, rght_opn_q);
`else
    lft_opn_new_s  = opn_next(lft_rd_q);
    rght_opn_new_s = opn_next(a2d_res);
`endif

    diff_s  = $signed({1'b0, lft_rd_q}) - $signed({1'b0, a2d_res});
    delta_s = {diff_s[12], diff_s} - {diff_prev_q[12], diff_prev_q};
    shift_s = delta_s >>> D_SHIFT;
    if (shift_s > 14'sd255) begin
      dtrm_sat_s = 9'h0FF;
    end else if (shift_s < -14'sd256) begin
      dtrm_sat_s = 9'h100;
    end else begin
      dtrm_sat_s = shift_s[8:0];
    end

    a2d_strt_d = (state_d == ST_CNV_L) || (state_d == ST_CNV_R);
    if (state_d == ST_CNV_L) begin
      a2d_chnl_d = LFT_CHNL;
    end else if (state_d == ST_CNV_R) begin
      a2d_chnl_d = RGHT_CHNL;
    end else begin
      a2d_chnl_d = a2d_chnl_q;
    end
    ir_en_d  = (state_d == ST_SETTLE) || (state_d == ST_CNV_L) || (state_d == ST_WAIT_L) ||
               (state_d == ST_CNV_R)  || (state_d == ST_WAIT_R);
    ir_vld_d = upd_s;

    if (upd_s) begin
      lft_ir_d    = lft_rd_q;
      rght_ir_d   = a2d_res;
      lft_opn_d   = lft_opn_new_s;
      rght_opn_d  = rght_opn_new_s;
      diff_prev_d = diff_s;
      first_d     = 1'b0;
      if (first_q || lft_opn_new_s || rght_opn_new_s) begin
        ir_dtrm_d = 9'd0;
      end else begin
        ir_dtrm_d = dtrm_sat_s;
      end
    end else begin
      lft_ir_d    = lft_ir_q;
      rght_ir_d   = rght_ir_q;
      lft_opn_d   = lft_opn_q;
      rght_opn_d  = rght_opn_q;
      diff_prev_d = diff_prev_q;
      first_d     = first_q;
      ir_dtrm_d   = ir_dtrm_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, captured reading, derivative history and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q    <= 20'd0;
      settle_cnt_q <= 16'd0;
      lft_rd_q     <= 12'd0;
      diff_prev_q  <= 13'sd0;
      first_q      <= 1'b1;
      a2d_strt_q   <= 1'b0;
      a2d_chnl_q   <= LFT_CHNL;
      ir_en_q      <= 1'b0;
      lft_ir_q     <= 12'd0;
      rght_ir_q    <= 12'd0;
      lft_opn_q    <= 1'b1;
      rght_opn_q   <= 1'b1;
      ir_dtrm_q    <= 9'd0;
      ir_vld_q     <= 1'b0;
    end else begin
      per_cnt_q    <= per_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      lft_rd_q     <= lft_rd_d;
      diff_prev_q  <= diff_prev_d;
      first_q      <= first_d;
      a2d_strt_q   <= a2d_strt_d;
      a2d_chnl_q   <= a2d_chnl_d;
      ir_en_q      <= ir_en_d;
      lft_ir_q     <= lft_ir_d;
      rght_ir_q    <= rght_ir_d;
      lft_opn_q    <= lft_opn_d;
      rght_opn_q   <= rght_opn_d;
      ir_dtrm_q    <= ir_dtrm_d;
      ir_vld_q     <= ir_vld_d;
    end
  end

  assign a2d_strt = a2d_strt_q;
  assign a2d_chnl = a2d_chnl_q;
  assign IR_en    = ir_en_q;
  assign lft_IR   = lft_ir_q;
  assign rght_IR  = rght_ir_q;
  assign lft_opn  = lft_opn_q;
  assign rght_opn = rght_opn_q;
  assign IR_Dtrm  = ir_dtrm_q;
  assign IR_vld   = ir_vld_q;

endmodule

// File: tb/tb_ir_sense_seq.sv
// Scoreboard bench for ir_sense_seq (PERIOD=64, SETTLE=8) with a 5-cycle A2D model.
module tb_ir_sense_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, a2d_cnv_cmplt;
  logic [11:0] a2d_res;
  logic        a2d_strt, IR_en, lft_opn, rght_opn, IR_vld;
  logic [2:0]  a2d_chnl;
  logic [11:0] lft_IR, rght_IR;
  logic [8:0]  IR_Dtrm;

  typedef struct packed {
    logic [11:0] l;
    logic [11:0] r;
    logic        lo;
    logic        ro;
    logic [8:0]  d;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          vld_cnt = 0;
  int          strt_total = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          strt_idx = 0;
  logic [11:0] cur_lft = 12'd0;
  logic [11:0] cur_rght = 12'd0;

  ir_sense_seq #(.PERIOD(20'd64), .SETTLE(16'd8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res),
    .a2d_strt(a2d_strt), .a2d_chnl(a2d_chnl), .IR_en(IR_en), .lft_IR(lft_IR), .rght_IR(rght_IR),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .IR_Dtrm(IR_Dtrm), .IR_vld(IR_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strt"},  {31'd0, a2d_strt}, 32'd0);
    chk({tag, "_chnl"},  {29'd0, a2d_chnl}, 32'd3);
    chk({tag, "_IR_en"}, {31'd0, IR_en},    32'd0);
    chk({tag, "_lft"},   {20'd0, lft_IR},   32'd0);
    chk({tag, "_rght"},  {20'd0, rght_IR},  32'd0);
    chk({tag, "_lopn"},  {31'd0, lft_opn},  32'd1);
    chk({tag, "_ropn"},  {31'd0, rght_opn}, 32'd1);
    chk({tag, "_dtrm"},  {23'd0, IR_Dtrm},  32'd0);
    chk({tag, "_vld"},   {31'd0, IR_vld},   32'd0);
  endtask

  // Cycle count since reset release; the period counter restarts with it.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) cyc = 0;
      else        cyc++;
    end
  end

  // A2D model: answers each request 5 cycles later with the reading for its channel.
  initial begin
    a2d_cnv_cmplt = 1'b0;
    a2d_res       = 12'd0;
    forever begin
      @(negedge clk);
      if (a2d_strt) begin
        logic [2:0] ch;
        ch = a2d_chnl;
        repeat (5) @(posedge clk);
        #1;
        a2d_res       = (ch == 3'd3) ? cur_lft : cur_rght;
        a2d_cnv_cmplt = 1'b1;
        @(posedge clk);
        #1;
        a2d_cnv_cmplt = 1'b0;
      end
    end
  end

  // Sequencing monitor: emitter rise on the tick, request timing and channels.
  initial begin
    logic en_prev;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && IR_en && !en_prev) begin
        chk("IR_en_rise_on_tick", cyc % 64, 32'd0);
        rise_cyc = cyc;
        strt_idx = 0;
      end
      if (rst_n && a2d_strt) begin
        strt_total++;
        if (strt_idx == 0) begin
          chk("strt1_cycle", cyc, rise_cyc + 8);
          chk("strt1_chnl", {29'd0, a2d_chnl}, 32'd3);
        end else begin
          chk("strt2_chnl", {29'd0, a2d_chnl}, 32'd0);
          chk("strt2_IR_en", {31'd0, IR_en}, 32'd1);
        end
        strt_idx++;
      end
      en_prev = IR_en;
    end
  end

  // Scoreboard monitor: every IR_vld pops one expected sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && IR_vld) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_vld: IR_vld=1 at cycle %0d, no sample pending", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("lft_IR",   {20'd0, lft_IR},   {20'd0, e.l});
          chk("rght_IR",  {20'd0, rght_IR},  {20'd0, e.r});
          chk("lft_opn",  {31'd0, lft_opn},  {31'd0, e.lo});
          chk("rght_opn", {31'd0, rght_opn}, {31'd0, e.ro});
          chk("IR_Dtrm",  {23'd0, IR_Dtrm},  {23'd0, e.d});
          chk("IR_en_low_at_vld", {31'd0, IR_en}, 32'd0);
        end
      end
    end
  end

  task automatic run_sample(input logic [11:0] l, input logic [11:0] r,
                            input logic lo, input logic ro, input logic [8:0] d);
    exp_t e;
    int   n0;
    e.l = l; e.r = r; e.lo = lo; e.ro = ro; e.d = d;
    cur_lft  = l;
    cur_rght = r;
    exp_q.push_back(e);
    n0 = vld_cnt;
    for (int i = 0; i < 200 && vld_cnt == n0; i++) @(negedge clk);
    chk("sample_done_in_time", {31'd0, vld_cnt != n0}, 32'd1);
  endtask

  initial begin
    int s0, v0;
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    run_sample(12'h900, 12'h900, 1'b0, 1'b0, 9'h000);
    run_sample(12'h980, 12'h900, 1'b0, 1'b0, 9'h020);
    run_sample(12'h900, 12'h980, 1'b0, 1'b0, 9'h1C0);
    run_sample(12'h800, 12'h800, 1'b0, 1'b0, 9'h020);
    run_sample(12'hFFF, 12'h000, 1'b0, 1'b1, 9'h000);
    run_sample(12'h000, 12'hFFF, 1'b1, 1'b0, 9'h000);
`ifdef IR_HYST_EN
    run_sample(12'h400, 12'hFFF, 1'b1, 1'b0, 9'h000);
`else
    run_sample(12'h400, 12'hFFF, 1'b0, 1'b0, 9'h0FF);
`endif
    run_sample(12'hFFF, 12'h400, 1'b0, 1'b0, 9'h0FF);
    run_sample(12'h400, 12'hFFF, 1'b0, 1'b0, 9'h100);
    run_sample(12'h3F0, 12'h900, 1'b1, 1'b0, 9'h000);
`ifdef IR_HYST_EN
    run_sample(12'h450, 12'h900, 1'b1, 1'b0, 9'h000);
`else
    run_sample(12'h450, 12'h900, 1'b0, 1'b0, 9'h018);
`endif
    run_sample(12'h490, 12'h900, 1'b0, 1'b0, 9'h010);

    // One full period with en low: no request, no update.
    en = 1'b0;
    s0 = strt_total;
    v0 = vld_cnt;
    repeat (64) @(negedge clk);
    chk("en_off_no_strt", strt_total - s0, 32'd0);
    chk("en_off_no_vld", vld_cnt - v0, 32'd0);
    en = 1'b1;
    run_sample(12'h900, 12'h900, 1'b0, 1'b0, 9'h0FF);

    // Reset while waiting for the right conversion; its late completion must be ignored.
    cur_lft  = 12'h500;
    cur_rght = 12'h600;
    for (int i = 0; i < 200 && !(a2d_strt && a2d_chnl == 3'd0); i++) @(negedge clk);
    chk("abort_strt2_seen", {31'd0, a2d_strt}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vld_cnt;
    repeat (40) @(negedge clk);
    chk("late_cmplt_no_vld", vld_cnt - v0, 32'd0);
    chk("late_cmplt_lft_IR", {20'd0, lft_IR}, 32'd0);
    chk("late_cmplt_IR_en", {31'd0, IR_en}, 32'd0);

    run_sample(12'h980, 12'h900, 1'b0, 1'b0, 9'h000);
    run_sample(12'h900, 12'h900, 1'b0, 1'b0, 9'h1E0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
